// File: rtl/mux3_3_pkg.sv
// ============================================================================
// Module   : mux3_3_pkg
// Brief    : Select-code constants and default data width for mux3_3_sel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux3_3_pkg;

  localparam int unsigned DEF_WIDTH = 3;

  localparam logic [1:0] SEL_E0  = 2'b00;
  localparam logic [1:0] SEL_E1  = 2'b01;
  localparam logic [1:0] SEL_E2  = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mux3_3_sel_reg.sv
// ============================================================================
// Module   : mux3_3_sel_reg
// Brief    : WIDTH-bit D register with asynchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux3_3_sel_reg #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mux3_3_sel.sv
// ============================================================================
// Module   : mux3_3_sel
// Brief    : 3-way WIDTH-bit selector with combinational and registered result.
//            Define MUX3_3_SEL_ERRO_EN to add the sticky Erro output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux3_3_sel
  import mux3_3_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [1:0]       Controle,
  output logic [WIDTH-1:0] Resultado,
  output logic [WIDTH-1:0] ResultadoReg,
  output logic             SelInvalido
`ifdef MUX3_3_SEL_ERRO_EN
  ,
  output logic             Erro
`endif
);

  logic [WIDTH-1:0] w_resultado;
  logic             w_sel_invalido;

  // Unknown select codes fall into the default arm, giving all-zero.
  always_comb begin
    w_resultado    = '0;
    w_sel_invalido = 1'b0;
    case (Controle)
      SEL_E0:  w_resultado = Entrada0;
      SEL_E1:  w_resultado = Entrada1;
      SEL_E2:  w_resultado = Entrada2;
      SEL_INV: w_sel_invalido = 1'b1;
      default: w_resultado = '0;
    endcase
  end

  assign Resultado   = w_resultado;
  assign SelInvalido = w_sel_invalido;

  mux3_3_sel_reg #(
    .WIDTH (WIDTH)
  ) u_resultado_reg (
    .clk (clock),
    .rst (reset),
    .i_d (w_resultado),
    .o_q (ResultadoReg)
  );

`ifdef MUX3_3_SEL_ERRO_EN
  logic r_erro;

  // Set-only; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_erro <= 1'b0;
    end else if (w_sel_invalido) begin
      r_erro <= 1'b1;
    end
  end

  assign Erro = r_erro;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux3_3_sel.sv
// ============================================================================
// Module   : tb_mux3_3_sel
// Brief    : Self-checking bench for mux3_3_sel (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux3_3_sel;

  localparam int W = 3;

  logic         clock;
  logic         reset;
  logic [W-1:0] e0, e1, e2;
  logic [1:0]   ctl;
  logic [W-1:0] res, res_reg;
  logic         inv;
`ifdef MUX3_3_SEL_ERRO_EN
  logic         erro;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux3_3_sel #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .Entrada0     (e0),
    .Entrada1     (e1),
    .Entrada2     (e2),
    .Controle     (ctl),
    .Resultado    (res),
    .ResultadoReg (res_reg),
    .SelInvalido  (inv)
`ifdef MUX3_3_SEL_ERRO_EN
    ,
    .Erro         (erro)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: select code indexes the list of inputs; code 3 selects nothing.
  function automatic logic [W-1:0] model_sel(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [1:0] s);
    logic [W-1:0] ins[3];
    ins[0] = a; ins[1] = b; ins[2] = c;
    return (int'(s) < 3) ? ins[int'(s)] : '0;
  endfunction

  typedef struct packed {
    logic [W-1:0] a, b, c;
    logic [1:0]   s;
    logic [W-1:0] exp_res;
    logic         exp_inv;
  } vec_t;

  vec_t vecs[8];

  logic [W-1:0] exp_prev;
  logic         exp_erro;

  initial begin
    vecs[0] = '{3'b111, 3'b010, 3'b000, 2'b00, 3'b111, 1'b0};
    vecs[1] = '{3'b111, 3'b010, 3'b000, 2'b01, 3'b010, 1'b0};
    vecs[2] = '{3'b111, 3'b010, 3'b000, 2'b10, 3'b000, 1'b0};
    vecs[3] = '{3'b111, 3'b010, 3'b000, 2'b11, 3'b000, 1'b1};
    vecs[4] = '{3'b001, 3'b110, 3'b101, 2'b10, 3'b101, 1'b0};
    vecs[5] = '{3'b011, 3'b100, 3'b110, 2'b01, 3'b100, 1'b0};
    vecs[6] = '{3'b101, 3'b100, 3'b110, 2'b00, 3'b101, 1'b0};
    vecs[7] = '{3'b111, 3'b111, 3'b111, 2'b11, 3'b000, 1'b1};

    reset = 1'b1;
    e0 = 3'b111; e1 = 3'b010; e2 = 3'b000; ctl = 2'b00;
    #2;
    check("reset_resreg", res_reg, 0);
    check("reset_res_comb", res, 3'b111);
`ifdef MUX3_3_SEL_ERRO_EN
    check("reset_erro", erro, 0);
`endif

    // Table vectors while held in reset: combinational path is live.
    for (int i = 0; i < 8; i++) begin
      e0 = vecs[i].a; e1 = vecs[i].b; e2 = vecs[i].c; ctl = vecs[i].s;
      #1;
      check($sformatf("table%0d_res", i), res, vecs[i].exp_res);
      check($sformatf("table%0d_inv", i), inv, vecs[i].exp_inv);
      check($sformatf("table%0d_resreg", i), res_reg, 0);
    end

    // T1
    e0 = 3'b111; e1 = 3'b010; e2 = 3'b000; ctl = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t1_res", res, 3'b111);
    check("t1_inv", inv, 0);
    @(posedge clock); #1;
    check("t1_resreg", res_reg, 3'b111);

    // T2
    @(negedge clock);
    ctl = 2'b01; #1; check("t2_res01", res, 3'b010);
    ctl = 2'b10; #1; check("t2_res10", res, 3'b000);
    ctl = 2'b00; #1; check("t2_res00", res, 3'b111);

    // T3
    @(negedge clock);
    ctl = 2'b11; #1;
    check("t3_res", res, 3'b000);
    check("t3_inv", inv, 1);
    @(posedge clock); #1;
    check("t3_resreg", res_reg, 3'b000);
`ifdef MUX3_3_SEL_ERRO_EN
    check("t3_erro_set", erro, 1);
`endif
    ctl = 2'b00;
    @(posedge clock); #1;
    check("t3_inv_clear", inv, 0);
`ifdef MUX3_3_SEL_ERRO_EN
    check("t3_erro_sticky", erro, 1);
`endif

    // T4
    ctl = 2'b01;
    @(posedge clock); #1;
    check("t4_resreg_pre", res_reg, 3'b010);
    #2;
    reset = 1'b1; #1;
    check("t4_resreg_async", res_reg, 3'b000);
    check("t4_res", res, 3'b010);
`ifdef MUX3_3_SEL_ERRO_EN
    check("t4_erro", erro, 0);
`endif

    // T5
    @(negedge clock);
    reset = 1'b0; #1;
    check("t5_resreg_hold", res_reg, 3'b000);
    @(posedge clock); #1;
    check("t5_resreg_load", res_reg, 3'b010);

    // T6
    @(negedge clock);
    e1 = 3'b101; #1;
    check("t6_res", res, 3'b101);
    check("t6_resreg_old", res_reg, 3'b010);
    @(posedge clock); #1;
    check("t6_resreg_new", res_reg, 3'b101);

    // Random stimulus against the reference model.
    exp_erro = 1'b0;
    @(negedge clock);
    reset = 1'b1; #1;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      e0  = W'($urandom);
      e1  = W'($urandom);
      e2  = W'($urandom);
      ctl = 2'($urandom_range(0, 3));
      #1;
      exp_prev = model_sel(e0, e1, e2, ctl);
      check("rand_res", res, exp_prev);
      check("rand_inv", inv, (ctl == 2'd3));
      if (ctl == 2'd3) exp_erro = 1'b1;
      @(posedge clock); #1;
      check("rand_resreg", res_reg, exp_prev);
`ifdef MUX3_3_SEL_ERRO_EN
      check("rand_erro", erro, exp_erro);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
